// File: rtl/serial_add_pkg.sv
// rtl/serial_add_pkg.sv - shared FSM state type and default width for serial_add_seq
package serial_add_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/full_adder_cell.sv
// rtl/full_adder_cell.sv - single-bit full adder used by the serial adder datapath
module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_add_seq.sv
// rtl/serial_add_seq.sv - bit-serial LSB-first adder, one bit per clock; SERIAL_ADD_ACC_EN enables accumulate mode
module serial_add_seq
    import serial_add_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             cin,
    input  logic             acc_mode,
    input  logic             acc_clr,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t           r_state;
    state_t           w_next_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_work;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;
    logic             r_cout;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] w_op_a;
    logic             w_clr;
    logic             w_accept;
    logic             w_last;
    logic             w_fa_sum;
    logic             w_fa_cout;

`ifdef SERIAL_ADD_ACC_EN
    // Clear wins over start when both arrive in the same IDLE cycle.
    assign w_clr  = (r_state == ST_IDLE) && acc_clr;
    assign w_op_a = acc_mode ? r_sum : op_a;
`else
    logic w_unused;
    assign w_unused = acc_mode ^ acc_clr;
    assign w_clr    = 1'b0;
    assign w_op_a   = op_a;
`endif

    assign w_accept = (r_state == ST_IDLE) && start && !w_clr;
    assign w_last   = (r_cnt == LAST_BIT);

    full_adder_cell u_fa (
        .a    (r_a[0]),
        .b    (r_b[0]),
        .cin  (r_carry),
        .sum  (w_fa_sum),
        .cout (w_fa_cout)
    );

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:  if (w_accept) w_next_state = ST_SHIFT;
            ST_SHIFT: if (w_last)   w_next_state = ST_DONE;
            ST_DONE:  w_next_state = ST_IDLE;
            default:  w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_work  <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            if (w_accept) begin
                r_a     <= w_op_a;
                r_b     <= op_b;
                r_carry <= cin;
                r_work  <= '0;
                r_cnt   <= '0;
            end else if (r_state == ST_SHIFT) begin
                r_a     <= r_a >> 1;
                r_b     <= r_b >> 1;
                r_carry <= w_fa_cout;
                r_work  <= {w_fa_sum, r_work[WIDTH-1:1]};
                r_cnt   <= r_cnt + 1'b1;
                // The final bit goes straight into the visible result.
                if (w_last) begin
                    r_sum  <= {w_fa_sum, r_work[WIDTH-1:1]};
                    r_cout <= w_fa_cout;
                end
            end
            if (w_clr) begin
                r_sum  <= '0;
                r_cout <= 1'b0;
            end
        end
    end

    assign ready = (r_state == ST_IDLE);
    assign busy  = (r_state == ST_SHIFT);
    assign done  = (r_state == ST_DONE);
    assign sum   = r_sum;
    assign cout  = r_cout;

endmodule

// File: tb/tb_serial_add_seq.sv
// tb/tb_serial_add_seq.sv - scoreboard bench for serial_add_seq; accumulate steps built with SERIAL_ADD_ACC_EN
module tb_serial_add_seq;

    localparam int W = 8;

    typedef struct packed {
        logic [W-1:0] s;
        logic         c;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         cin;
    logic         acc_mode;
    logic         acc_clr;
    logic         ready;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;

    exp_t         sb[$];
    int           checks = 0;
    int           errors = 0;
    logic [W-1:0] m_sum = '0;
    logic         m_cout = 1'b0;

    serial_add_seq #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .op_a     (op_a),
        .op_b     (op_b),
        .cin      (cin),
        .acc_mode (acc_mode),
        .acc_clr  (acc_clr),
        .ready    (ready),
        .busy     (busy),
        .done     (done),
        .sum      (sum),
        .cout     (cout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic [W-1:0] a, input logic [W-1:0] b, input logic c, input logic mode);
        logic [W-1:0] a_eff;
        logic [W:0]   t;
        exp_t         e;
        a_eff = a;
`ifdef SERIAL_ADD_ACC_EN
        if (mode) a_eff = m_sum;
`else
        if (mode) a_eff = a;
`endif
        t   = {1'b0, a_eff} + {1'b0, b} + {{W{1'b0}}, c};
        e.s = t[W-1:0];
        e.c = t[W];
        sb.push_back(e);
    endtask

    // Starts at a negedge; runs 2*W+2 further cycles watching for done pulses.
    // disturb_k: drive a spurious start with junk operands after cycle k.
    // rst_k: assert reset after cycle k (operation is then aborted).
    task automatic do_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic c, input logic mode, input logic clr,
                         input int disturb_k, input int rst_k);
        int   n_done;
        int   lat;
        exp_t e;
        n_done = 0;
        lat    = -1;
        if (rst_k == 0) push_exp(a, b, c, mode);
        start = 1'b1; op_a = a; op_b = b; cin = c; acc_mode = mode; acc_clr = clr;
        @(negedge clk);
        start = 1'b0; acc_clr = 1'b0; acc_mode = 1'b0;
        op_a = W'($urandom); op_b = W'($urandom); cin = 1'($urandom);
        chk({tag, "_busy"}, busy, 1'b1);
        chk({tag, "_hold_sum"}, {cout, sum}, {m_cout, m_sum});
        for (int k = 1; k <= 2 * W + 2; k++) begin
            @(negedge clk);
            start = 1'b0;
            chk({tag, "_onehot"}, $onehot({ready, busy, done}), 1'b1);
            if (rst_k > 0 && k == rst_k + 1) begin
                rst = 1'b0;
                chk({tag, "_rst_ready"}, ready, 1'b1);
                chk({tag, "_rst_sum"}, {cout, sum}, '0);
                m_sum = '0;
                m_cout = 1'b0;
            end
            if (lat > 0 && k == lat + 1) chk({tag, "_ready_after"}, ready, 1'b1);
            if (done === 1'b1) begin
                n_done++;
                if (lat < 0) lat = k;
                chk({tag, "_sb_nonempty"}, sb.size() > 0, 1'b1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    chk({tag, "_sum"}, sum, e.s);
                    chk({tag, "_cout"}, cout, e.c);
                    m_sum = e.s;
                    m_cout = e.c;
                end
            end
            if (k == disturb_k) begin
                start = 1'b1; op_a = '1; op_b = '1; cin = 1'b1;
            end
            if (k == rst_k) rst = 1'b1;
        end
        if (rst_k > 0) begin
            chk({tag, "_no_done"}, n_done, 0);
        end else begin
            chk({tag, "_done_count"}, n_done, 1);
            chk({tag, "_latency"}, lat, W);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; op_a = '0; op_b = '0; cin = 1'b0;
        acc_mode = 1'b0; acc_clr = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_ready", ready, 1'b1);
        chk("reset_busy", busy, 1'b0);
        chk("reset_done", done, 1'b0);
        chk("reset_sum", sum, '0);
        chk("reset_cout", cout, 1'b0);
        rst = 1'b0;
        @(negedge clk);

        do_op("zero", 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 0, 0);
        do_op("ovf", 8'hFF, 8'h01, 1'b0, 1'b0, 1'b0, 0, 0);
        do_op("a5_5a", 8'hA5, 8'h5A, 1'b1, 1'b0, 1'b0, 0, 0);
        do_op("restart_ign", 8'h03, 8'h04, 1'b0, 1'b0, 1'b0, 2, 0);
        do_op("mid_reset", 8'h55, 8'h22, 1'b1, 1'b0, 1'b0, 0, 3);
        do_op("max_cin", 8'hFF, 8'hFF, 1'b1, 1'b0, 1'b0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            do_op("rand", W'($urandom), W'($urandom), 1'($urandom), 1'b0, 1'b0, 0, 0);
        end

`ifdef SERIAL_ADD_ACC_EN
        acc_clr = 1'b1;
        @(negedge clk);
        acc_clr = 1'b0;
        chk("acc_clr_sum", {cout, sum}, '0);
        chk("acc_clr_ready", ready, 1'b1);
        m_sum = '0;
        m_cout = 1'b0;
        for (int i = 0; i < 3; i++) begin
            do_op("acc", W'($urandom), 8'h10, 1'b0, 1'b1, 1'b0, 0, 0);
        end
        chk("acc_final", sum, 8'h30);
        start = 1'b1; acc_clr = 1'b1; op_a = 8'h11; op_b = 8'h22;
        @(negedge clk);
        start = 1'b0; acc_clr = 1'b0;
        chk("clr_prio_sum", {cout, sum}, '0);
        chk("clr_prio_busy", busy, 1'b0);
        chk("clr_prio_ready", ready, 1'b1);
        m_sum = '0;
        m_cout = 1'b0;
        for (int k = 0; k < W + 2; k++) begin
            @(negedge clk);
            chk("clr_prio_idle", {busy, done}, 2'b00);
        end
`else
        do_op("acc_ignored", 8'h12, 8'h34, 1'b0, 1'b1, 1'b1, 0, 0);
`endif

        chk("sb_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_add_seq.md
SERIAL_ADD_SEQ -- requirements
Module: serial_add_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning operand/result width in bits (legal range 2..16).
REQ-002 SHALL have port clk  input  1  single system clock; all state changes on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port start  input  1  request to begin an addition; sampled only in IDLE.
REQ-005 SHALL have port op_a  input  WIDTH  addend A; latched on the start-accept edge.
REQ-006 SHALL have port op_b  input  WIDTH  addend B; latched on the start-accept edge.
REQ-007 SHALL have port cin  input  1  carry-in for bit 0; latched on the start-accept edge.
REQ-008 SHALL have port acc_mode  input  1  use previous sum as A (functional only with the macro in REQ-024).
REQ-009 SHALL have port acc_clr  input  1  clear held sum (functional only with the macro in REQ-024).
REQ-010 SHALL have port ready  output  1  high in IDLE.
REQ-011 SHALL have port busy  output  1  high in SHIFT.
REQ-012 SHALL have port done  output  1  one-cycle pulse, high in DONE.
REQ-013 SHALL have port sum  output  WIDTH  result of the last completed addition.
REQ-014 SHALL have port cout  output  1  carry-out of the MSB from the last completed addition.

Function
REQ-015 SHALL implement FSM IDLE -> SHIFT on start=1 in IDLE; SHIFT -> DONE after exactly WIDTH bit-cycles; DONE -> IDLE unconditionally after one cycle.
REQ-016 SHALL, in SHIFT, add one bit per cycle LSB-first through a 1-bit full adder, with a carry register initialised from the latched cin and updated from the adder's carry-out each cycle.
REQ-017 SHALL shift each sum bit into a working register; sum/cout outputs update only on the SHIFT->DONE edge and then hold until the next completion.
REQ-018 SHALL assert done exactly WIDTH+1 rising edges after the start-accept edge (done is high in the cycle following edge N+WIDTH, where N is the start-accept edge).
REQ-019 SHALL ignore start while busy or in DONE: no restart, no operand relatch.
REQ-020 SHALL compute modulo 2^WIDTH in sum with overflow visible only on cout; e.g., all-ones + 1 gives sum=0 and cout=1.
REQ-021 SHALL keep ready, busy, and done mutually exclusive and one-hot across IDLE/SHIFT/DONE.
REQ-022 SHALL ignore op_a/op_b/cin changes after the start-accept edge for the in-flight operation.

Reset
REQ-023 SHALL, with rst=1 on a rising edge, force IDLE; ready=1, busy=0, done=0, sum=0, cout=0; carry and working registers=0; aborting any in-flight operation with no done pulse.

Configuration
REQ-024 SHALL, with SERIAL_ADD_ACC_EN defined, use held sum as operand A (op_a ignored) when acc_mode=1 at start accept; acc_clr=1 in IDLE zeroes sum and cout on the next edge; acc_clr has priority over start in the same cycle (start is dropped).
REQ-025 SHALL, without SERIAL_ADD_ACC_EN, keep acc_mode and acc_clr as ports but ignore them functionally; operand A is always op_a.

Structure
REQ-026 SHALL place the FSM state enum and the default WIDTH constant in shared package serial_add_pkg.
REQ-027 SHALL instantiate exactly one sub-module, full_adder_cell (inputs a, b, cin; outputs sum, cout), for the per-bit addition.

Verification
REQ-028 SHALL cover: WIDTH=8, reset, then start with op_a=8'h00, op_b=8'h00, cin=0 -> done after 9 edges, sum=8'h00, cout=0, ready back next cycle.
REQ-029 SHALL cover: op_a=8'hFF, op_b=8'h01, cin=0 -> sum=8'h00, cout=1; and op_a=8'hA5, op_b=8'h5A, cin=1 -> sum=8'h00, cout=1.
REQ-030 SHALL cover: op_a=8'h03, op_b=8'h04 started, then start pulsed with op_a=8'hFF in SHIFT cycle 3 -> single done, sum=8'h07, cout=0.
REQ-031 SHALL cover: rst=1 asserted in SHIFT cycle 4 -> next cycle ready=1, sum=0, cout=0, no done pulse ever emitted.
REQ-032 SHALL cover, with SERIAL_ADD_ACC_EN: acc_clr, then three starts with acc_mode=1, op_b=8'h10 -> sums 8'h10, 8'h20, 8'h30.
REQ-033 SHALL cover, with SERIAL_ADD_ACC_EN: start and acc_clr both asserted in the same IDLE cycle -> sum cleared, no operation starts, busy stays 0.
